// File: rtl/intr_evt_capture.sv
// Interrupt event capture: synchronise SoC interrupt lines, detect per-channel edges,
// and queue {channel, level, timestamp} events in a FIFO drained by valid/ready.
module intr_evt_capture #(
  parameter int NUM_INT    = 40,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 8,
  parameter bit SYNC_EN    = 1'b1,
  localparam int ID_W      = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NUM_INT-1:0] intr_in,
  input  logic [NUM_INT-1:0] intr_mode,
  input  logic [NUM_INT-1:0] intr_mask,
  input  logic [NUM_INT-1:0] clr_pend,
  input  logic               ovf_clr,
  output logic [NUM_INT-1:0] intr_sync,
  output logic [NUM_INT-1:0] pend,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_level,
  output logic [TS_W-1:0]    evt_ts,
  output logic               ovf_sticky,
  output logic [15:0]        drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);
  localparam logic [TS_W-1:0] TS_ONE  = TS_W'(1);

  logic [NUM_INT-1:0] s, s_d, det, grant, drop;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld, gnt_level;
  logic [6:0]         drop_num;
  logic [16:0]        drop_sum;
  logic [TS_W-1:0]    ts_cnt;
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               full, empty, push, pop;

  logic [ID_W-1:0]    mem_id  [FIFO_DEPTH];
  logic               mem_lvl [FIFO_DEPTH];
  logic [TS_W-1:0]    mem_ts  [FIFO_DEPTH];

  generate
    if (SYNC_EN) begin : g_sync
      logic [NUM_INT-1:0] sync_q1, sync_q2;
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          sync_q1 <= '0;
          sync_q2 <= '0;
        end else begin
          sync_q1 <= intr_in;
          sync_q2 <= sync_q1;
        end
      end
      assign s = sync_q2;
    end else begin : g_nosync
      assign s = intr_in;
    end
  endgenerate

  assign intr_sync = s;
  assign det = ~intr_mask & ((intr_mode & s & ~s_d) | (~intr_mode & (s ^ s_d)));

  // Lowest pending index wins; a full FIFO blocks the grant even if a pop is in flight.
  always_comb begin
    grant     = '0;
    gnt_id    = '0;
    gnt_vld   = 1'b0;
    gnt_level = 1'b0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (pend[i] && !gnt_vld && !full) begin
        gnt_vld   = 1'b1;
        gnt_id    = ID_W'(i);
        gnt_level = s_d[i];
        grant[i]  = 1'b1;
      end
    end
  end

  assign drop = det & pend & ~grant;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      drop_num = drop_num + 7'(drop[i]);
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_num);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s_d        <= '0;
      pend       <= '0;
      ts_cnt     <= '0;
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      s_d    <= s;
      pend   <= (pend & ~grant & ~clr_pend) | det;
      ts_cnt <= ts_cnt + TS_ONE;
      // Clearing in a drop cycle still accounts for that cycle's drops.
      if (ovf_clr) begin
        drop_cnt   <= 16'(drop_num);
        ovf_sticky <= |drop;
      end else begin
        drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        ovf_sticky <= ovf_sticky | (|drop);
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = gnt_vld;
  assign pop   = ~empty & evt_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_id[k]  <= '0;
        mem_lvl[k] <= 1'b0;
        mem_ts[k]  <= '0;
      end
    end else begin
      if (push) begin
        mem_id[wr_ptr[AW-1:0]]  <= gnt_id;
        mem_lvl[wr_ptr[AW-1:0]] <= gnt_level;
        mem_ts[wr_ptr[AW-1:0]]  <= ts_cnt;
        wr_ptr                  <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign evt_valid = ~empty;
  assign evt_id    = mem_id[rd_ptr[AW-1:0]];
  assign evt_level = mem_lvl[rd_ptr[AW-1:0]];
  assign evt_ts    = mem_ts[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_intr_evt_capture.sv
// Directed and random checks of intr_evt_capture against a queue-based event model.
module tb_intr_evt_capture;
  localparam int NI    = 40;
  localparam int TW    = 4;
  localparam int DEPTH = 8;
  localparam int IW    = 6;

  logic          clk, rst_b;
  logic [NI-1:0] intr_in, intr_mode, intr_mask, clr_pend;
  logic          ovf_clr, evt_ready;
  logic [NI-1:0] intr_sync, pend;
  logic          evt_valid, evt_level, ovf_sticky;
  logic [IW-1:0] evt_id;
  logic [TW-1:0] evt_ts;
  logic [15:0]   drop_cnt;

  intr_evt_capture #(.NUM_INT(NI), .TS_W(TW), .FIFO_DEPTH(DEPTH), .SYNC_EN(1'b1)) dut (
    .clk(clk), .rst_b(rst_b), .intr_in(intr_in), .intr_mode(intr_mode),
    .intr_mask(intr_mask), .clr_pend(clr_pend), .ovf_clr(ovf_clr),
    .intr_sync(intr_sync), .pend(pend), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_level(evt_level), .evt_ts(evt_ts),
    .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int id;
    bit lvl;
    int ts;
  } ev_t;

  // Reference: history of sampled lines, pending set, event queue, drop accounting.
  ev_t           m_q[$];
  logic [NI-1:0] m_hist[3];
  logic [NI-1:0] m_pend;
  int            m_ts, m_drop;
  bit            m_ovf;
  int            n_checks, n_errors;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_pend = '0;
    m_ts   = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  task automatic model_edge();
    logic [NI-1:0] sv, sdv, np;
    bit   full, d;
    int   gid, nd;
    ev_t  e;
    sv   = m_hist[1];
    sdv  = m_hist[2];
    full = (m_q.size() == DEPTH);
    gid  = -1;
    if (!full)
      for (int i = NI - 1; i >= 0; i--) if (m_pend[i]) gid = i;
    nd = 0;
    np = '0;
    for (int i = 0; i < NI; i++) begin
      d = !intr_mask[i] && (intr_mode[i] ? (sv[i] && !sdv[i]) : (sv[i] != sdv[i]));
      if (d && m_pend[i] && i != gid) nd++;
      np[i] = d || (m_pend[i] && i != gid && !clr_pend[i]);
    end
    if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
    if (gid >= 0) begin
      e.id  = gid;
      e.lvl = sdv[gid];
      e.ts  = m_ts;
      m_q.push_back(e);
    end
    m_pend = np;
    if (ovf_clr) begin
      m_drop = nd;
      m_ovf  = (nd > 0);
    end else begin
      m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
      if (nd > 0) m_ovf = 1;
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = intr_in;
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  task automatic model_check();
    chk("intr_sync", 64'(intr_sync), 64'(m_hist[1]));
    chk("pend", 64'(pend), 64'(m_pend));
    chk("evt_valid", 64'(evt_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("evt_id", 64'(evt_id), 64'(m_q[0].id));
      chk("evt_level", 64'(evt_level), 64'(m_q[0].lvl));
      chk("evt_ts", 64'(evt_ts), 64'(m_q[0].ts));
    end
    chk("ovf_sticky", 64'(ovf_sticky), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_valid"}, 64'(evt_valid), 64'd0);
    chk({tag, "_pend"}, 64'(pend), 64'd0);
    chk({tag, "_sync"}, 64'(intr_sync), 64'd0);
    chk({tag, "_id"}, 64'(evt_id), 64'd0);
    chk({tag, "_level"}, 64'(evt_level), 64'd0);
    chk({tag, "_ts"}, 64'(evt_ts), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_sticky), 64'd0);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    int t0, guard, rate;
    logic [63:0] r1, r2, r3;
    n_checks = 0;
    n_errors = 0;
    rst_b = 1'b0;
    intr_in = '0;
    intr_mode = '1;
    intr_mask = '0;
    clr_pend = '0;
    ovf_clr = 1'b0;
    evt_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_b = 1'b1;

    // Single rise on ch5 before edge 10
    steps(9);
    intr_in[5] = 1'b1;
    step();
    steps(2);
    chk("rise_pend5", 64'(pend[5]), 64'd1);
    chk("rise_novalid", 64'(evt_valid), 64'd0);
    step();
    chk("rise_valid", 64'(evt_valid), 64'd1);
    chk("rise_id", 64'(evt_id), 64'd5);
    chk("rise_level", 64'(evt_level), 64'd1);
    chk("rise_ts", 64'(evt_ts), 64'd12);
    evt_ready = 1'b1;
    steps(2);
    evt_ready = 1'b0;
    intr_in[5] = 1'b0;
    steps(4);
    chk("fall_mode1_noevt", 64'(evt_valid), 64'd0);

    // Both-edge pulse on ch3
    intr_mode[3] = 1'b0;
    intr_in[3] = 1'b1;
    steps(4);
    intr_in[3] = 1'b0;
    steps(6);
    chk("both_id0", 64'(evt_id), 64'd3);
    chk("both_lvl0", 64'(evt_level), 64'd1);
    t0 = int'(evt_ts);
    evt_ready = 1'b1;
    step();
    chk("both_id1", 64'(evt_id), 64'd3);
    chk("both_lvl1", 64'(evt_level), 64'd0);
    chk("both_tsdiff", 64'(evt_ts), 64'((t0 + 4) % 16));
    step();
    evt_ready = 1'b0;
    chk("both_drained", 64'(evt_valid), 64'd0);

    // Same pulse with ch3 masked
    intr_mask[3] = 1'b1;
    intr_in[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) intr_in[3] = 1'b0;
      step();
      chk("mask_pend3", 64'(pend[3]), 64'd0);
      chk("mask_novalid", 64'(evt_valid), 64'd0);
    end
    intr_mask[3] = 1'b0;

    // Priority and backpressure on ch0..9
    intr_in[9:0] = '1;
    steps(14);
    chk("prio_pend98", 64'(pend[9:8]), 64'd3);
    chk("prio_pend_lo", 64'(pend[7:0]), 64'd0);
    chk("prio_head", 64'(evt_id), 64'd0);
    t0 = int'(evt_ts);
    steps(3);
    chk("stall_id", 64'(evt_id), 64'd0);
    chk("stall_ts", 64'(evt_ts), 64'(t0));
    evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("order_valid", 64'(evt_valid), 64'd1);
      chk("order_id", 64'(evt_id), 64'(k));
      step();
    end
    chk("order_empty", 64'(evt_valid), 64'd0);
    intr_mode[3] = 1'b1;
    intr_in[9:0] = '0;
    steps(4);
    evt_ready = 1'b0;

    // Overflow on ch2 in both-edge mode
    intr_mode[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      intr_in[2] = ~intr_in[2];
      steps(3);
    end
    steps(3);
    for (int k = 0; k < 3; k++) begin
      intr_in[2] = ~intr_in[2];
      steps(3);
    end
    steps(2);
    chk("ovf_drop2", 64'(drop_cnt), 64'd2);
    chk("ovf_sticky", 64'(ovf_sticky), 64'd1);
    chk("ovf_pend2", 64'(pend[2]), 64'd1);
    intr_in[2] = ~intr_in[2];
    steps(2);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovfclr_drop1", 64'(drop_cnt), 64'd1);
    chk("ovfclr_sticky", 64'(ovf_sticky), 64'd1);

    // Clear pending on ch7 while the FIFO is full
    intr_in[7] = 1'b1;
    steps(3);
    chk("clr_pre", 64'(pend[7]), 64'd1);
    clr_pend[7] = 1'b1;
    step();
    clr_pend[7] = 1'b0;
    chk("clr_done", 64'(pend[7]), 64'd0);
    intr_in[7] = 1'b0;
    steps(2);
    intr_in[7] = 1'b1;
    steps(2);
    clr_pend[7] = 1'b1;
    step();
    clr_pend[7] = 1'b0;
    chk("clr_vs_det", 64'(pend[7]), 64'd1);
    evt_ready = 1'b1;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    steps(12);
    chk("clr_drained", 64'(evt_valid), 64'd0);

    // Reset with events queued; held-high lines rise again after release
    evt_ready = 1'b0;
    intr_in[13:10] = '1;
    steps(8);
    chk("rst_pre_valid", 64'(evt_valid), 64'd1);
    rst_b = 1'b0;
    #1;
    model_reset();
    chk_all_zero("midreset");
    @(negedge clk);
    rst_b = 1'b1;
    steps(4);
    chk("post_rst_id", 64'(evt_id), 64'd7);
    chk("post_rst_ts", 64'(evt_ts), 64'd3);
    evt_ready = 1'b1;
    steps(10);
    intr_in = '0;
    steps(4);
    evt_ready = 1'b0;

    // Timestamp wrap: two channels detected together, granted at ts 15 and 0
    guard = 0;
    while (m_ts != 12 && guard < 20) begin
      step();
      guard++;
    end
    chk("wrap_align", 64'(m_ts), 64'd12);
    intr_in[21:20] = 2'b11;
    steps(5);
    chk("wrap_id0", 64'(evt_id), 64'd20);
    chk("wrap_ts15", 64'(evt_ts), 64'd15);
    evt_ready = 1'b1;
    step();
    chk("wrap_id1", 64'(evt_id), 64'd21);
    chk("wrap_ts0", 64'(evt_ts), 64'd0);
    intr_in = '0;
    steps(4);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rate = (c < 1500) ? 30 : 120;
      for (int i = 0; i < NI; i++)
        if ($urandom_range(0, rate - 1) == 0) intr_in[i] = ~intr_in[i];
      if ($urandom_range(0, 49) == 0) begin
        r1 = {$urandom(), $urandom()};
        intr_mode = r1[NI-1:0];
      end
      if ($urandom_range(0, 99) == 0) begin
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        r3 = {$urandom(), $urandom()};
        intr_mask = r1[NI-1:0] & r2[NI-1:0] & r3[NI-1:0];
      end
      clr_pend = '0;
      if ($urandom_range(0, 3) == 0) clr_pend[$urandom_range(0, NI - 1)] = 1'b1;
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 63) == 0);
      step();
    end
    clr_pend = '0;
    ovf_clr = 1'b0;
    intr_mask = '0;
    evt_ready = 1'b1;
    steps(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
